// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width, default FIFO
// geometry and the frame sequencer state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;
  localparam int unsigned UART_FIFO_AW    = $clog2(UART_FIFO_DEPTH);

  // Frame sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    SEQ_IDLE      = 2'd0,
    SEQ_LAUNCH    = 2'd1,
    SEQ_WAIT_DONE = 2'd2
  } seq_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO feeding the UART transmitter.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   wr_en/wr_data write port; a write while full is dropped unless a pop
//                 happens in the same cycle (the freed slot is reused)
//   rd_en         pop strobe; ignored while empty
//   rd_data_c     combinational view of the head entry
//   full, empty   registered occupancy flags
//   level         registered occupancy, 0..DEPTH
//   empty_next_c  combinational value empty will take at the next edge
//
// DEPTH must be a power of two (2..256) and AW must equal log2(DEPTH);
// pointers then wrap naturally modulo DEPTH.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned AW    = UART_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data_c,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   empty_next_c
);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   push_c;
  logic                   pop_c;
  logic [AW:0]            level_next_c;

  // A pop needs a registered non-empty FIFO; a write into a full FIFO is
  // accepted only when the same edge frees the head slot.
  assign pop_c  = rd_en & ~empty;
  assign push_c = wr_en & (~full | pop_c);

  // Occupancy after this edge.
  always_comb begin
    level_next_c = level;
    case ({push_c, pop_c})
      2'b10:   level_next_c = level + (AW+1)'(1);
      2'b01:   level_next_c = level - (AW+1)'(1);
      default: level_next_c = level;
    endcase
  end

  assign empty_next_c = (level_next_c == '0);

  // Pointer and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next_c;
      empty <= empty_next_c;
      full  <= (level_next_c == (AW+1)'(DEPTH));
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

  // Head is read before the edge, so a simultaneous write into the same
  // slot while full cannot disturb the byte being popped.
  assign rd_data_c = mem[rd_ptr];

endmodule : uart_sync_fifo

// File: rtl/uart_tx_feeder.sv
// Feeds queued host bytes to a UART transmitter one frame at a time.
//
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   tx_en       transmit enable; gates new frame launches only
//   wr_en       host write strobe, wr_data is the byte to enqueue
//   clr_ovf     clears the sticky overflow flag
//   tx_done     end-of-frame pulse from the transmitter
//   start_tx    one-cycle frame launch pulse
//   data_out    byte presented to the transmitter, held for the whole frame
//   full/empty/level  FIFO occupancy
//   busy        a launched frame is in flight
//   overflow    sticky: a host write was dropped
//   irq_txc     transmit complete: FIFO empty and no frame in flight
//
// All outputs are registers; flags are loaded from next-state values so
// they line up with the state they describe without any host-to-output
// combinational path.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH,
  parameter int unsigned AW    = UART_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_en,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   clr_ovf,
  input  logic                   tx_done,
  output logic                   start_tx,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   busy,
  output logic                   overflow,
  output logic                   irq_txc
);

  seq_state_e             state;
  seq_state_e             state_next_c;
  logic                   pop_c;
  logic                   wr_drop_c;
  logic                   fifo_empty_next_c;
  logic [UART_DATA_W-1:0] fifo_rd_data_c;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (pop_c),
    .rd_data_c    (fifo_rd_data_c),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .empty_next_c (fifo_empty_next_c)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEQ_IDLE;
    else       state <= state_next_c;
  end

  // Next state and pop decision. tx_en is only looked at in IDLE so a frame
  // already launched always runs to tx_done; there is deliberately no timeout.
  always_comb begin
    state_next_c = state;
    pop_c        = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (tx_en && !empty) begin
          pop_c        = 1'b1;
          state_next_c = SEQ_LAUNCH;
        end
      end
      SEQ_LAUNCH: begin
        state_next_c = SEQ_WAIT_DONE;
      end
      SEQ_WAIT_DONE: begin
        if (tx_done) state_next_c = SEQ_IDLE;
      end
      default: begin
        state_next_c = SEQ_IDLE;
      end
    endcase
  end

  // Write lost because the FIFO is full and nothing leaves this cycle.
  assign wr_drop_c = wr_en & full & ~pop_c;

  // Registered outputs. data_out only reloads on a pop, which cannot happen
  // before the edge that returns the sequencer to IDLE after tx_done, so the
  // byte stays stable for the transmitter's parity bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_tx <= 1'b0;
      busy     <= 1'b0;
      irq_txc  <= 1'b1;
      overflow <= 1'b0;
      data_out <= '0;
    end else begin
      start_tx <= (state_next_c == SEQ_LAUNCH);
      busy     <= (state_next_c != SEQ_IDLE);
      irq_txc  <= fifo_empty_next_c && (state_next_c == SEQ_IDLE);
      if (pop_c) data_out <= fifo_rd_data_c;
      // A drop wins over a coincident clear.
      if (wr_drop_c)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule : uart_tx_feeder

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: table-driven FIFO fill/overflow
// vectors, a transmitter model with a byte scoreboard, and hand sequences
// for the multi-cycle corner cases.
module tb_uart_tx_feeder;

  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int FRAME_CYC = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_en;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          tx_done;
  logic          start_tx;
  logic [7:0]    data_out;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          busy;
  logic          overflow;
  logic          irq_txc;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_start = 0;
  bit            gap_chk = 1'b0;
  logic [7:0]    sb_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic [7:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       irq;
  } vec_t;

  vec_t vecs[20];

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_en    (tx_en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .tx_done  (tx_done),
    .start_tx (start_tx),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .busy     (busy),
    .overflow (overflow),
    .irq_txc  (irq_txc)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    sb_q.push_back(b);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int c = 0;
    while ((busy || !empty || sb_q.size() != 0) && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    n_tests++;
    if (c >= max_cyc) begin
      n_fail++;
      $display("FAIL %s_drain: still busy=%b empty=%b queued=%0d after %0d cycles",
               name, busy, empty, sb_q.size(), c);
    end
  endtask

  task automatic wait_start(input string name, input int max_cyc);
    int c = 0;
    while (!start_tx && c < max_cyc) begin
      @(posedge clk); #1;
      c++;
    end
    check1({name, "_start_seen"}, start_tx, 1'b1);
  endtask

  // Transmitter model: checks each launched byte against the scoreboard,
  // holds the frame FRAME_CYC cycles, then pulses tx_done.
  initial begin : xmit_model
    logic [7:0] held;
    logic [7:0] exp_b;
    bit         stable;
    bit         aborted;
    bit         skip_wait;
    skip_wait = 1'b0;
    tx_done   = 1'b0;
    forever begin
      if (!skip_wait) begin
        @(posedge clk); #1;
      end
      skip_wait = 1'b0;
      if (!reset && start_tx) begin
        n_start++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_launch: start_tx with data %0h, nothing expected", data_out);
        end else begin
          exp_b = sb_q.pop_front();
          check8("frame_data", data_out, exp_b);
        end
        check1("busy_in_frame", busy, 1'b1);
        held    = data_out;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
          @(posedge clk); #1;
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (i == 0) check1("start_tx_one_cycle", start_tx, 1'b0);
          if (data_out !== held) stable = 1'b0;
        end
        if (!aborted) begin
          tx_done = 1'b1;
          @(posedge clk); #1;
          tx_done = 1'b0;
          if (!reset) begin
            if (data_out !== held) stable = 1'b0;
            check1("data_out_stable", stable, 1'b1);
            check1("busy_after_done", busy, 1'b0);
            if (gap_chk && sb_q.size() != 0 && tx_en) begin
              @(posedge clk); #1;
              check1("b2b_one_idle", start_tx, 1'b1);
              skip_wait = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned mdl_level;
    int          n0;

    // Vector table: fill to full, drop, drop with clear, clear alone, idle.
    for (int i = 0; i < DEPTH; i++)
      vecs[i] = '{wr: 1'b1, data: 8'(i + 1), clr: 1'b0, lvl: 8'(i + 1),
                  full: (i == DEPTH - 1), empty: 1'b0, ovf: 1'b0, irq: 1'b0};
    vecs[16] = '{wr: 1'b1, data: 8'h11, clr: 1'b0, lvl: 8'd16, full: 1'b1, empty: 1'b0, ovf: 1'b1, irq: 1'b0};
    vecs[17] = '{wr: 1'b1, data: 8'h12, clr: 1'b1, lvl: 8'd16, full: 1'b1, empty: 1'b0, ovf: 1'b1, irq: 1'b0};
    vecs[18] = '{wr: 1'b0, data: 8'h00, clr: 1'b1, lvl: 8'd16, full: 1'b1, empty: 1'b0, ovf: 1'b0, irq: 1'b0};
    vecs[19] = '{wr: 1'b0, data: 8'h00, clr: 1'b0, lvl: 8'd16, full: 1'b1, empty: 1'b0, ovf: 1'b0, irq: 1'b0};

    reset   = 1'b1;
    tx_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_start_tx", start_tx, 1'b0);
    check8("rst_data_out", data_out, 8'h00);
    check1("rst_busy", busy, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    check1("rst_empty", empty, 1'b1);
    check1("rst_full", full, 1'b0);
    check1("rst_irq_txc", irq_txc, 1'b1);
    check8("rst_level", 8'(level), 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single byte: pop on the edge after the write, start_tx in LAUNCH.
    @(negedge clk);
    tx_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    sb_q.push_back(8'hA5);
    @(posedge clk); #1;
    check8("a5_level_after_write", 8'(level), 8'd1);
    check1("a5_no_start_yet", start_tx, 1'b0);
    check1("a5_irq_low", irq_txc, 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    check1("a5_start", start_tx, 1'b1);
    check8("a5_data_out", data_out, 8'hA5);
    check1("a5_busy", busy, 1'b1);
    check8("a5_level_after_pop", 8'(level), 8'd0);
    @(posedge clk); #1;
    check1("a5_start_cleared", start_tx, 1'b0);
    check1("a5_busy_wait", busy, 1'b1);
    wait_drain("a5", 50);
    check1("a5_irq_done", irq_txc, 1'b1);

    // Table-driven fill with tx_en low, overflow and clear behaviour.
    mdl_level = 0;
    @(negedge clk);
    tx_en = 1'b0;
    foreach (vecs[k]) begin
      @(negedge clk);
      wr_en   = vecs[k].wr;
      wr_data = vecs[k].data;
      clr_ovf = vecs[k].clr;
      if (vecs[k].wr && mdl_level < DEPTH) begin
        sb_q.push_back(vecs[k].data);
        mdl_level++;
      end
      @(posedge clk); #1;
      check8($sformatf("vec%0d_level", k), 8'(level), vecs[k].lvl);
      check1($sformatf("vec%0d_full", k), full, vecs[k].full);
      check1($sformatf("vec%0d_empty", k), empty, vecs[k].empty);
      check1($sformatf("vec%0d_overflow", k), overflow, vecs[k].ovf);
      check1($sformatf("vec%0d_irq", k), irq_txc, vecs[k].irq);
    end
    @(negedge clk);
    wr_en   = 1'b0;
    clr_ovf = 1'b0;

    // Full FIFO: pop and write on the same edge; new byte goes out last.
    n0 = n_start;
    @(negedge clk);
    tx_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    sb_q.push_back(8'h99);
    gap_chk = 1'b1;
    @(posedge clk); #1;
    check8("fullrw_level", 8'(level), 8'd16);
    check1("fullrw_full", full, 1'b1);
    check1("fullrw_no_overflow", overflow, 1'b0);
    check8("fullrw_first_byte", data_out, 8'h01);
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain("fullrw", 600);
    gap_chk = 1'b0;
    check8("fullrw_frame_count", 8'(n_start - n0), 8'd17);
    check1("fullrw_irq", irq_txc, 1'b1);

    // tx_en dropped mid-frame: frame completes, nothing further launches.
    @(negedge clk);
    tx_en = 1'b0;
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    push_byte(8'hC4);
    @(negedge clk);
    wr_en = 1'b0;
    tx_en = 1'b1;
    wait_start("txen", 20);
    @(posedge clk);
    @(negedge clk);
    tx_en = 1'b0;
    n0 = n_start;
    repeat (FRAME_CYC + 12) @(posedge clk);
    #1;
    check8("txen_no_launch", 8'(n_start - n0), 8'd0);
    check8("txen_level_held", 8'(level), 8'd3);
    check1("txen_busy_idle", busy, 1'b0);
    check1("txen_irq_low", irq_txc, 1'b0);
    @(negedge clk);
    tx_en = 1'b1;
    wait_drain("txen", 200);
    check8("txen_resumed", 8'(n_start - n0), 8'd3);

    // Reset during WAIT_DONE with 5 bytes queued.
    @(negedge clk);
    tx_en = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'hD0 + 8'(i));
    @(negedge clk);
    wr_en = 1'b0;
    tx_en = 1'b1;
    wait_start("rst", 20);
    @(posedge clk); #1;
    check8("rst_mid_level_before", 8'(level), 8'd5);
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    check8("rst_mid_level", 8'(level), 8'd0);
    check1("rst_mid_busy", busy, 1'b0);
    check1("rst_mid_irq", irq_txc, 1'b1);
    check1("rst_mid_empty", empty, 1'b1);
    check8("rst_mid_data_out", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    n0 = n_start;
    repeat (12) @(posedge clk);
    #1;
    check8("rst_mid_no_launch", 8'(n_start - n0), 8'd0);
    check1("rst_mid_still_idle", busy, 1'b0);
    push_byte(8'hE7);
    @(negedge clk);
    wr_en = 1'b0;
    wait_drain("rst_new", 50);
    check8("rst_new_launch", 8'(n_start - n0), 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_feeder
